multi_channel_timer: RTL
========================

// Module: multi_channel_timer
// PURPOSE
//   Multi-channel successor to the single elapsed-seconds timer. A shared prescaler turns clk into
//   a one-cycle tick every PRESC_DIV cycles (1 s at 80 MHz by default). N_CH independent channels
//   count ticks in free-run, periodic or one-shot mode, compare against a per-channel value, and
//   raise sticky interrupts. No divider: seconds come from the prescaler, not from count/freq.
// PARAMETERS
//   PRESC_DIV  80000000  clk cycles per tick (>=2); prescaler width = $clog2(PRESC_DIV)
//   N_CH       4         number of channels (1..16)
//   CNT_W      32        channel counter / compare width
// PORTS
//   clk       in   1           single clock
//   reset     in   1           synchronous reset, active-high
//   start     in   N_CH        per-channel start/restart pulse
//   stop      in   N_CH        per-channel stop pulse
//   mode      in   2*N_CH      per-channel mode, ch i at [2i+1:2i]; sampled on start
//   cmp_val   in   CNT_W*N_CH  per-channel compare, ch i at [CNT_W*i +: CNT_W]; sampled on start
//   irq_clr   in   N_CH        per-channel W1C interrupt clear
//   count     out  CNT_W*N_CH  per-channel current count, in ticks
//   running   out  N_CH        1 while the channel is in RUN
//   irq       out  N_CH        sticky per-channel interrupt
//   tick      out  1           registered prescaler pulse, 1 clk wide
// BEHAVIOUR
//   Reset: synchronous and active-high; same-cycle effect on all state. prescaler=0, tick=0,
//     count=0, running=0, irq=0, all channels IDLE, latched mode/cmp=0. A mid-run reset aborts.
//   Prescaler: free-running from reset. It counts 0..PRESC_DIV-1 and wraps. tick=1 in the cycle
//     after the prescaler holds PRESC_DIV-1, so there is one tick per PRESC_DIV clks.
//   Modes: 00 FREE, 01 PERIODIC, 10 ONESHOT, 11 reserved (decodes as FREE).
//   Channel FSM states: IDLE, RUN, DONE.
//     start (any state): count<=0; latch mode and cmp_val; ->RUN. A start in RUN restarts.
//     stop: RUN->IDLE and count holds. Start+stop in the same cycle: stop wins. start is ignored.
//     A tick while not in RUN has no effect.
//   Counting, on a tick while in RUN (nxt = count+1, mod 2^CNT_W):
//     FREE: count<=nxt. When count==all-ones it wraps to 0 and sets irq. The compare is ignored.
//     PERIODIC: if nxt==cmp: count<=0, irq set, stay RUN. Else count<=nxt.
//     ONESHOT: if nxt==cmp: count<=cmp, irq set, ->DONE (count frozen). Else count<=nxt.
//     cmp==0 in PERIODIC/ONESHOT: never matches. The counter wraps as FREE with no irq.
//   Latency: count, irq and state update in the clk where tick=1; visible the next cycle.
//   irq: sticky until irq_clr. Set and clear in the same cycle: set wins. A clear while no set
//     is pending gives irq=0 the next cycle.
//   start does not clear irq; only irq_clr or reset does.
//   running = (state==RUN), registered. All outputs are registered.
//   Channels are fully independent and share only tick.
// STRUCTURE
//   timer_pkg: mode localparams (MODE_FREE/PERIODIC/ONESHOT), state encodings
//     (ST_IDLE/RUN/DONE), and a 2-bit state width.
//   Sub-module timer_channel (CNT_W): one FSM + counter + irq. Instantiated N_CH times in a
//     generate loop. The top level holds the prescaler and port slicing.
// TESTING  (PRESC_DIV=4, N_CH=4, CNT_W=8 unless noted)
//   1 Reset: hold reset for 3 clks mid-count -> count=0, irq=0, running=0, tick=0 next cycle;
//     first tick 4 clks after release.
//   2 PERIODIC, ch0 cmp=3: start -> irq rises after the 3rd tick (12 clks after start).
//     Count sequence 0,1,2,0,1,2. irq_clr and a match in the same clk -> irq stays 1.
//   3 ONESHOT, ch1 cmp=5: start -> after the 5th tick count=5, running=0, irq=1.
//     Further ticks leave count=5. A restart gives count=0 and running=1.
//   4 FREE, ch2: start -> after 256 ticks count wraps 255->0 and irq=1. cmp_val is ignored.
//   5 Start+stop on ch3 in the same clk while in RUN -> IDLE, count held. A change to cmp_val
//     during RUN has no effect until the next start.
//   6 cmp=0 in PERIODIC -> no irq over 300 ticks and count wraps.
//     Default params: tick period = 80000000 clks (check 1 period only).

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timer: channel modes and channel FSM states.
package timer_pkg;

    localparam int STATE_W = 2;

    localparam logic [1:0] MODE_FREE     = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The reserved encoding 11 behaves exactly like free-run.
    function automatic logic [1:0] decode_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_FREE : m;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, tick counter with compare, and a sticky interrupt.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             irq
);

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   cmp_q, cmp_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;
    logic               running_q, running_d;
    logic [CNT_W-1:0]   nxt;
    logic               cmp_hit;
    logic               wrap;
    logic               irq_set;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cmp_d   = cmp_q;
        count_d = count_q;
        irq_set = 1'b0;
        nxt     = count_q + CNT_W'(1);
        wrap    = (count_q == '1);
        // A zero compare can only be reached by wrapping, which must not count as a match.
        cmp_hit = (cmp_q != '0) && (nxt == cmp_q);

        if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (start) begin
            count_d = '0;
            mode_d  = mode;
            cmp_d   = cmp_val;
            state_d = ST_RUN;
        end else if (tick && (state_q == ST_RUN)) begin
            case (decode_mode(mode_q))
                MODE_PERIODIC: begin
                    if (cmp_hit) begin
                        count_d = '0;
                        irq_set = 1'b1;
                    end else begin
                        count_d = nxt;
                    end
                end
                MODE_ONESHOT: begin
                    if (cmp_hit) begin
                        count_d = cmp_q;
                        irq_set = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        count_d = nxt;
                    end
                end
                default: begin
                    count_d = nxt;
                    irq_set = wrap;
                end
            endcase
        end

        irq_d     = irq_set | (irq_q & ~irq_clr);
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_FREE;
            cmp_q     <= '0;
            count_q   <= '0;
            irq_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cmp_q     <= cmp_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
            running_q <= running_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign irq     = irq_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Shared prescaler producing a one-clock tick every PRESC_DIV cycles, fanned out to N_CH
// independent timer channels.
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int PRESC_DIV = 80000000,
    parameter int N_CH      = 4,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [CNT_W*N_CH-1:0] cmp_val,
    input  logic [N_CH-1:0]       irq_clr,
    output logic [CNT_W*N_CH-1:0] count,
    output logic [N_CH-1:0]       running,
    output logic [N_CH-1:0]       irq,
    output logic                  tick
);

    localparam int                 PRESC_W   = $clog2(PRESC_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;

    always_comb begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        tick_d  = (presc_q == PRESC_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    // Channels see the registered tick, so counting happens in the cycle where tick is high.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick_q),
            .start   (start[i]),
            .stop    (stop[i]),
            .mode    (mode[2*i +: 2]),
            .cmp_val (cmp_val[CNT_W*i +: CNT_W]),
            .irq_clr (irq_clr[i]),
            .count   (count[CNT_W*i +: CNT_W]),
            .running (running[i]),
            .irq     (irq[i])
        );
    end

endmodule
